mem_access_unit: RTL and testbench

//  Load/store sequencer between the multi-cycle datapath and the word-wide, big-endian Data_Memory.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Load/store request bus plus memory-side signals of mem_access_unit.
// slave = sequencer view, master = datapath/memory view.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] Daddr;
  logic [31:0] DataIn;
  logic        mRD;
  logic        mWR;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata,
    output rdata, done, err, busy, Daddr, DataIn, mRD, mWR
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata,
    input  rdata, done, err, busy, Daddr, DataIn, mRD, mWR
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-wide big-endian data memory.
// Ports: CLK, Reset (sync, active-high), bus (request side + memory side).
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input  logic             CLK,
  input  logic             Reset,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] datain_q, datain_d;

  // request checks, evaluated on the live bus in IDLE
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        range_bad;
  logic        align_bad;
  logic        req_err;

  always_comb begin
    unique case (bus.size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap into range
  assign end_addr  = {1'b0, bus.addr} + {30'd0, nbytes};
  assign range_bad = end_addr > 33'(ADDR_LIMIT);
  assign align_bad = (bus.size == 2'b11)
                   | ((bus.size == 2'b01) & bus.addr[0])
                   | ((bus.size == 2'b10) & (|bus.addr[1:0]));
  assign req_err   = range_bad | align_bad;

  // lane extraction, big-endian: offset 0 is the MSB lane
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    unique case (off_q)
      2'd0:    rd_byte = bus.mem_rdata[31:24];
      2'd1:    rd_byte = bus.mem_rdata[23:16];
      2'd2:    rd_byte = bus.mem_rdata[15:8];
      default: rd_byte = bus.mem_rdata[7:0];
    endcase
  end

  assign rd_half = off_q[1] ? bus.mem_rdata[15:0]
                            : bus.mem_rdata[31:16];

  always_comb begin
    unique case (size_q)
      2'b00:
        load_val = sext_q ? {{24{rd_byte[7]}}, rd_byte}
                          : {24'd0, rd_byte};
      2'b01:
        load_val = sext_q ? {{16{rd_half[15]}}, rd_half}
                          : {16'd0, rd_half};
      default:
        load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == 2'b00) begin
      unique case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    sext_d   = sext_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    daddr_d  = daddr_q;
    datain_d = datain_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          sext_d  = bus.sign_ext;
          off_d   = bus.addr[1:0];
          wdata_d = bus.wdata[15:0];
          daddr_d = {bus.addr[31:2], 2'b00};
          err_d   = req_err;
          if (req_err) begin
            state_d = S_DONE;
          end else if (bus.we && bus.size == 2'b10) begin
            datain_d = bus.wdata;
            state_d  = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          datain_d = merged;
          state_d  = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= 16'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      daddr_q  <= 32'd0;
      datain_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      daddr_q  <= daddr_d;
      datain_q <= datain_d;
    end
  end

  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = (state_q == S_DONE) & err_q;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.mRD    = (state_q == S_RD);
  assign bus.mWR    = (state_q == S_WR);
  assign bus.rdata  = rdata_q;
  assign bus.Daddr  = daddr_q;
  assign bus.DataIn = datain_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array reference model.
// Backing memory is a 64-word array written on the falling edge.
module tb_mem_access_unit;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_LIMIT(256)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.Daddr[7:2]];
  always @(negedge CLK) if (bus.mWR) mem[bus.Daddr[7:2]] <= bus.DataIn;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [256];
  logic [31:0] last_rd = 32'd0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdc = 0;
  int wrc = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: memory as a flat byte array, MSB at the lowest address.
  function automatic exp_t model(bit w, logic [1:0] sz, bit sx,
                                 logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int nb;
    longint ea;
    logic [31:0] v;
    logic [31:0] m;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea = longint'(a) + nb;
    e.err = (sz == 2'b11) || (ea > 256) || (a % nb != 0);
    e.nrd = 0;
    e.nwr = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++)
        ref_mem[a + i] = 8'(wd >> (8 * (nb - 1 - i)));
      e.nwr = 1;
      e.nrd = (nb == 4) ? 0 : 1;
      e.lat = (nb == 4) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[a + i]);
      if (nb < 4 && sx && v[8 * nb - 1]) begin
        m = (32'h1 << (8 * nb)) - 1;
        v = v | ~m;
      end
      last_rd = v;
      e.nrd = 1;
      e.lat = 2;
    end
    e.rdata = last_rd;
    return e;
  endfunction

  // Monitor: counts memory strobes and checks each done pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (Reset) begin
      rdc = 0;
      wrc = 0;
    end else begin
      if (bus.mRD) rdc++;
      if (bus.mWR) wrc++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("err", 32'(bus.err), 32'(e.err));
          chk("rdata", bus.rdata, e.rdata);
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("mRD_cycles", 32'(rdc), 32'(e.nrd));
          chk("mWR_cycles", 32'(wrc), 32'(e.nwr));
        end
        rdc = 0;
        wrc = 0;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge CLK);
    while (bus.busy) begin
      t++;
      if (t > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL idle_timeout at cycle %0d", cyc);
        return;
      end
      @(negedge CLK);
    end
  endtask

  task automatic drive(bit w, logic [1:0] sz, bit sx,
                       logic [31:0] a, logic [31:0] wd);
    bus.req      = 1'b1;
    bus.we       = w;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.wdata    = wd;
  endtask

  task automatic scramble();
    bus.req      = 1'b0;
    bus.we       = 1'($urandom);
    bus.size     = 2'($urandom);
    bus.sign_ext = 1'($urandom);
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
  endtask

  task automatic issue(bit w, logic [1:0] sz, bit sx,
                       logic [31:0] a, logic [31:0] wd);
    exp_t e;
    wait_idle();
    e = model(w, sz, sx, a, wd);
    e.acc = cyc + 1;
    sbq.push_back(e);
    drive(w, sz, sx, a, wd);
    @(negedge CLK);
    scramble();
  endtask

  task automatic reset_mid_rd();
    wait_idle();
    drive(1'b1, 2'b00, 1'b0, 32'h0A, 32'hAB);
    @(negedge CLK);
    scramble();
    chk("rst_in_rd_mRD", 32'(bus.mRD), 32'd1);
    Reset = 1'b1;
    @(negedge CLK);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mWR", 32'(bus.mWR), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    last_rd = 32'd0;
    Reset = 1'b0;
    @(negedge CLK);
    chk("rst_after_done", 32'(bus.done), 32'd0);
    chk("rst_after_mWR", 32'(bus.mWR), 32'd0);
  endtask

  task automatic held_req();
    exp_t e1;
    exp_t e2;
    int t;
    wait_idle();
    e1 = model(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    e1.acc = cyc + 1;
    e2 = model(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    e2.acc = e1.acc + e1.lat + 1;
    sbq.push_back(e1);
    sbq.push_back(e2);
    drive(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (cyc < e2.acc && t < 20);
    scramble();
  endtask

  initial begin
    int mode;
    bit w;
    logic [1:0] sz;
    logic [31:0] a;
    int t;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    scramble();
    repeat (3) @(negedge CLK);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_Daddr", bus.Daddr, 32'd0);
    chk("reset_DataIn", bus.DataIn, 32'd0);
    chk("reset_mRD_mWR", {30'd0, bus.mRD, bus.mWR}, 32'd0);
    Reset = 1'b0;

    issue(1, 2'b10, 0, 32'h08, 32'h11223344);
    issue(0, 2'b10, 0, 32'h08, 32'h0);
    issue(1, 2'b10, 0, 32'h08, 32'h112233C4);
    issue(0, 2'b00, 1, 32'h0B, 32'h0);
    issue(0, 2'b00, 0, 32'h0B, 32'h0);
    issue(0, 2'b00, 1, 32'h09, 32'h0);
    issue(1, 2'b10, 0, 32'h08, 32'h11223344);
    issue(1, 2'b00, 0, 32'h0A, 32'hFFFFFFAB);
    issue(0, 2'b10, 0, 32'h08, 32'h0);
    issue(0, 2'b01, 1, 32'h0A, 32'h0);
    issue(0, 2'b10, 0, 32'h06, 32'h0);
    issue(0, 2'b01, 1, 32'h03, 32'h0);
    issue(1, 2'b10, 0, 32'hFE, 32'hDEADBEEF);
    issue(0, 2'b11, 0, 32'h10, 32'h0);
    issue(1, 2'b10, 0, 32'hFC, 32'hCAFEF00D);
    issue(0, 2'b10, 0, 32'hFC, 32'h0);
    issue(0, 2'b10, 0, 32'h100, 32'h0);
    issue(0, 2'b00, 1, 32'hFF, 32'h0);
    issue(0, 2'b01, 0, 32'hFFFFFFFE, 32'h0);

    reset_mid_rd();
    issue(0, 2'b10, 0, 32'h08, 32'h0);
    held_req();

    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 19);
      w = 1'($urandom);
      sz = (mode == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (mode < 3) a = 32'($urandom_range(248, 263));
      else if (mode < 5) a = $urandom;
      else a = 32'($urandom_range(0, 255));
      if (mode >= 6) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      issue(w, sz, 1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
